// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op and FSM state encodings shared by the sequential ALU
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - iterative shift-add unsigned multiplier datapath
module shift_add_mul #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               last_o
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  logic [RW-1:0]    mcand_q, mcand_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    acc_sum;

  // The accumulator value after this iteration; on the last step it is the product.
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product_o = acc_sum;
  assign last_o    = (cnt_q == CW'(WIDTH - 1));

  // Load operands on accept, then shift multiplicand left / multiplier right per step.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_sum;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  // Datapath registers; cleared on reset so an aborted multiply leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - clocked ALU with start/busy/done handshake and iterative multiply
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         sel,
  output logic [2*WIDTH-1:0] Y,
  output logic               zero,
  output logic               done,
  output logic               busy
);

  localparam int RW = 2 * WIDTH;

  state_e        state_q, state_d;
  logic [RW-1:0] y_q, y_d;
  logic          zero_q, zero_d;
  logic          done_q, done_d;

  logic [RW-1:0] a_ext, b_ext;
  logic [RW-1:0] single_res;
  logic [RW-1:0] mul_product;
  logic          mul_last;
  logic          accept;
  logic          mul_load;
  logic          mul_step;

  assign a_ext    = {{WIDTH{1'b0}}, A};
  assign b_ext    = {{WIDTH{1'b0}}, B};
  // Starts are only seen in IDLE, so a request during a multiply is simply dropped.
  assign accept   = start && (state_q == S_IDLE);
  assign mul_load = accept && (sel == OP_MUL);
  assign mul_step = (state_q == S_MUL);

  shift_add_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .load_i   (mul_load),
    .step_i   (mul_step),
    .a_i      (A),
    .b_i      (B),
    .product_o(mul_product),
    .last_o   (mul_last)
  );

  // Single-cycle ops at full result width; SUB wraps to a sign-extended two's-complement value.
  always_comb begin
    single_res = '0;
    case (sel)
      OP_ADD:  single_res = a_ext + b_ext;
      OP_SUB:  single_res = a_ext - b_ext;
      OP_AND:  single_res = a_ext & b_ext;
      default: single_res = '0;
    endcase
  end

  // FSM next state and result-register updates; done is a one-cycle pulse by default-low.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (sel == OP_MUL) begin
            state_d = S_MUL;
          end else begin
            y_d    = single_res;
            zero_d = (single_res == '0);
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mul_last) begin
          y_d     = mul_product;
          zero_d  = (mul_product == '0);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and visible result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign Y    = y_q;
  assign zero = zero_q;
  assign done = done_q;
  assign busy = (state_q == S_MUL);

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu at WIDTH=4 and WIDTH=2
module tb_seq_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       st4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [1:0] sel4 = '0;
  logic [7:0] y4;
  logic       z4, d4, bz4;

  logic       st2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic [1:0] sel2 = '0;
  logic [3:0] y2;
  logic       z2, d2, bz2;

  seq_alu #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .A(a4), .B(b4), .sel(sel4),
    .Y(y4), .zero(z4), .done(d4), .busy(bz4)
  );

  seq_alu #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .A(a2), .B(b2), .sel(sel2),
    .Y(y2), .zero(z2), .done(d2), .busy(bz2)
  );

  typedef struct {
    logic [7:0] y;
    logic       z;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] y;
  } vec_t;

  exp_t q4[$];
  exp_t q2[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_done4 = 0;
  int   n_done2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_op(input int w, input int a, input int b, input logic [1:0] s);
    int r;
    int m;
    m = (1 << (2 * w)) - 1;
    case (s)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      default: r = a * b;
    endcase
    return r & m;
  endfunction

  // Scoreboard: every done pops one expected result and checks value, zero flag and latency.
  always @(negedge clk) begin
    exp_t e;
    if (d4) begin
      n_done4++;
      if (q4.size() == 0) begin
        chk("w4_unexpected_done", 32'(d4), 32'(0));
      end else begin
        e = q4.pop_front();
        chk("w4_y", 32'(y4), 32'(e.y));
        chk("w4_zero", 32'(z4), 32'(e.z));
        chk("w4_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (d2) begin
      n_done2++;
      if (q2.size() == 0) begin
        chk("w2_unexpected_done", 32'(d2), 32'(0));
      end else begin
        e = q2.pop_front();
        chk("w2_y", 32'(y2), 32'(e.y));
        chk("w2_zero", 32'(z2), 32'(e.z));
        chk("w2_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drives one start pulse right after a rising edge and pushes the expected result.
  task automatic issue(input int w, input int a, input int b, input logic [1:0] s, input int ey);
    exp_t e;
    @(posedge clk);
    #1;
    e.y   = ey[7:0];
    e.z   = (ey == 0);
    e.cyc = cyc + 1 + ((s == OP_MUL) ? w : 0);
    if (w == 4) begin
      st4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; sel4 = s;
      q4.push_back(e);
    end else begin
      st2 = 1'b1; a2 = a[1:0]; b2 = b[1:0]; sel2 = s;
      q2.push_back(e);
    end
    @(posedge clk);
    #1;
    st4 = 1'b0;
    st2 = 1'b0;
  endtask

  task automatic drain(input int w);
    int n;
    n = 0;
    while (((w == 4) ? q4.size() : q2.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (((w == 4) ? q4.size() : q2.size()) != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL w%0d_done_timeout: no done within %0d cycles, required one", w, n);
      if (w == 4) q4.delete();
      else q2.delete();
    end
  endtask

  vec_t vecs[11];
  int   dn0;

  initial begin
    vecs[0]  = '{OP_ADD, 4'hF, 4'h1, 8'h10};
    vecs[1]  = '{OP_SUB, 4'h3, 4'h3, 8'h00};
    vecs[2]  = '{OP_SUB, 4'h1, 4'h2, 8'hFF};
    vecs[3]  = '{OP_AND, 4'hC, 4'hA, 8'h08};
    vecs[4]  = '{OP_ADD, 4'h0, 4'h0, 8'h00};
    vecs[5]  = '{OP_ADD, 4'hF, 4'hF, 8'h1E};
    vecs[6]  = '{OP_SUB, 4'h0, 4'hF, 8'hF1};
    vecs[7]  = '{OP_AND, 4'hF, 4'h0, 8'h00};
    vecs[8]  = '{OP_MUL, 4'hF, 4'hD, 8'hC3};
    vecs[9]  = '{OP_MUL, 4'h0, 4'h7, 8'h00};
    vecs[10] = '{OP_MUL, 4'hF, 4'hF, 8'hE1};

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w4_y", 32'(y4), 32'(0));
    chk("rst_w4_zero", 32'(z4), 32'(0));
    chk("rst_w4_done", 32'(d4), 32'(0));
    chk("rst_w4_busy", 32'(bz4), 32'(0));
    chk("rst_w2_y", 32'(y2), 32'(0));
    chk("rst_w2_busy", 32'(bz2), 32'(0));
    rst = 1'b0;

    // Table of hand-computed vectors
    for (int i = 0; i < 11; i++) begin
      issue(4, int'(vecs[i].a), int'(vecs[i].b), vecs[i].sel, int'(vecs[i].y));
      drain(4);
    end

    // MUL busy window and Y hold while iterating
    issue(4, 'hC, 'hA, OP_AND, 'h08);
    drain(4);
    issue(4, 'hF, 'hD, OP_MUL, 'hC3);
    for (int i = 0; i < 4; i++) begin
      chk("mul_busy_high", 32'(bz4), 32'(1));
      chk("mul_y_hold", 32'(y4), 32'(8'h08));
      chk("mul_no_early_done", 32'(d4), 32'(0));
      @(posedge clk);
      #1;
    end
    chk("mul_busy_low_at_done", 32'(bz4), 32'(0));
    chk("mul_done_pulse", 32'(d4), 32'(1));
    drain(4);

    // Start during an in-flight multiply is ignored
    dn0 = n_done4;
    issue(4, 3, 5, OP_MUL, 'h0F);
    @(posedge clk);
    #1;
    st4 = 1'b1; a4 = 4'h1; b4 = 4'h1; sel4 = OP_ADD;
    @(posedge clk);
    #1;
    st4 = 1'b0;
    drain(4);
    repeat (6) @(posedge clk);
    #1;
    chk("ignored_start_done_count", 32'(n_done4 - dn0), 32'(1));

    // Start held across the done cycle: MUL then ADD back-to-back
    begin
      exp_t e;
      st4 = 1'b1; a4 = 4'h2; b4 = 4'h3; sel4 = OP_MUL;
      e.y = 8'h06; e.z = 1'b0; e.cyc = cyc + 1 + 4;
      q4.push_back(e);
      @(posedge clk);
      #1;
      a4 = 4'h7; b4 = 4'h7; sel4 = OP_ADD;
      e.y = 8'h0E; e.z = 1'b0; e.cyc = cyc + 5;
      q4.push_back(e);
      repeat (5) @(posedge clk);
      #1;
      st4 = 1'b0;
      drain(4);
    end

    // Reset in the middle of a multiply aborts it without a done
    issue(4, 'hF, 'hF, OP_MUL, 'hE1);
    @(posedge clk);
    #1;
    q4.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_y", 32'(y4), 32'(0));
    chk("midrst_busy", 32'(bz4), 32'(0));
    chk("midrst_done", 32'(d4), 32'(0));
    chk("midrst_zero", 32'(z4), 32'(0));
    rst = 1'b0;
    dn0 = n_done4;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_late_done", 32'(n_done4 - dn0), 32'(0));

    // Exhaustive sweeps against the reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(4, a, b, OP_MUL, ref_op(4, a, b, OP_MUL));
        drain(4);
      end
    end
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          issue(2, a, b, 2'(s), ref_op(2, a, b, 2'(s)));
          drain(2);
        end
      end
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the team's 2-bit combinational ALU.
- Operand width is generic; one op set covers add, subtract, AND and unsigned multiply.
- Multiply is an iterative shift-add over WIDTH cycles; the other ops complete in one cycle.
- A start/busy/done handshake makes it usable as a datapath unit under a lab-level controller FSM.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..16); result width is 2*WIDTH.

Ports:
- clk    input   1          rising-edge clock
- rst    input   1          synchronous, active-high reset
- start  input   1          request; sampled only when busy=0
- A      input   WIDTH      operand A (unsigned)
- B      input   WIDTH      operand B (unsigned)
- sel    input   2          op: 00 ADD, 01 SUB, 10 AND, 11 MUL
- Y      output  2*WIDTH    registered result; holds until the next result is written
- zero   output  1          registered; 1 when written Y == 0
- done   output  1          one-cycle pulse when Y/zero are updated
- busy   output  1          1 while a MUL is iterating

Behaviour:
- Reset (rst=1 at a rising edge):
  - Y=0, zero=0, done=0, busy=0, FSM to IDLE.
  - Reset mid-MUL aborts the multiply, returns to IDLE and produces no done pulse.
- FSM states:
  - IDLE: start=1 at edge k latches A, B, sel.
    - ADD/SUB/AND: Y, zero, done=1 written at edge k; state stays IDLE.
    - MUL: state goes to MUL at edge k.
  - MUL: runs WIDTH iterations at edges k+1..k+WIDTH.
    - At edge k+WIDTH: Y=product, zero, done=1, state to IDLE.
- busy equals (state==MUL): 1 from edge k to edge k+WIDTH, 0 in the done cycle.
- Latency from the start cycle to done visible:
  - ADD/SUB/AND: 1 cycle.
  - MUL: WIDTH+1 cycles.
- done is high for exactly one cycle per accepted start; otherwise 0.
- start while busy=1 is ignored: not queued, and A/B/sel changes have no effect.
- start in the cycle where done=1 is accepted, allowing back-to-back ops.
- Arithmetic (all results zero-extended or truncated to 2*WIDTH):
  - ADD: Y = A+B, with the carry landing in bit WIDTH.
  - SUB: Y = A-B as a 2*WIDTH two's-complement value, sign-extended (e.g. WIDTH=4, 1-2 gives 8'hFF).
  - AND: Y = {WIDTH'b0, A&B}.
  - MUL: Y = A*B unsigned, exact in 2*WIDTH bits.
- MUL iteration: the multiplier register is shifted right each cycle, and the accumulator adds the shifted multiplicand when the multiplier LSB is 1.
  - The internal accumulator is used; Y holds its previous value during MUL.
- zero is recomputed at every done; otherwise held.
- Zero operands are not special-cased: MUL with A=0 or B=0 still takes WIDTH cycles.

Decomposition:
- Package alu_pkg holds:
  - Op encodings: OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_MUL=2'b11.
  - FSM state encoding: S_IDLE, S_MUL.
- Sub-module shift_add_mul (parameter WIDTH): iteration counter, multiplicand/multiplier/accumulator registers, and a last-iteration flag.
- seq_alu owns the FSM, the single-cycle ops, the Y/zero/done registers, and the start acceptance logic.

Test Plan:
- rst=1 for 2 cycles mid-MUL (A=4'hF, B=4'hF, 2 cycles after start) -> Y=0, busy=0, done=0, no later done pulse.
- WIDTH=4, ADD A=4'hF B=4'h1 -> next cycle Y=8'h10, zero=0, done=1 for 1 cycle. SUB A=4'h3 B=4'h3 -> Y=8'h00, zero=1.
- SUB A=4'h1 B=4'h2 -> Y=8'hFF. AND A=4'hC B=4'hA -> Y=8'h08.
- MUL A=4'hF B=4'hD -> busy high 4 cycles, done 5 cycles after start, Y=8'hC3. Y holds its previous value while busy.
- start pulsed (ADD 1+1) during an in-flight MUL 3*5 -> ignored; only done with Y=8'h0F, then nothing.
- start held high across the done cycle: MUL 2*3 then ADD 7+7 -> Y=8'h06, then on the very next cycle Y=8'h0E. Exhaustive MUL sweep over WIDTH=2 and WIDTH=4 against a reference model.
